// File: rtl/memory.sv
// memory: single-port synchronous SRAM with a valid/ready handshake.
// One request per two cycles; reset clears all words asynchronously.
module memory #(
  parameter int SIZE       = 1024,
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 512,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic                  wr_rd_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [WIDTH-1:0]      rdata_o
);
  typedef enum logic {IDLE, RESP} state_t;
  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             hit;
  if (SIZE != DEPTH * WIDTH / 8) begin : g_size_chk
    $error("memory: SIZE must equal DEPTH*WIDTH/8");
  end
  // Only matters for non-power-of-two DEPTH: out-of-range writes drop, reads return 0.
  assign hit = int'(addr_i) < DEPTH;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      ready_o <= 1'b0;
      rdata_o <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == IDLE) begin
      if (valid_i) begin
        ready_o <= 1'b1;
        state   <= RESP;
        if (wr_rd_i) begin
          if (hit) mem[addr_i] <= wdata_i;
        end else begin
          rdata_o <= hit ? mem[addr_i] : '0;
        end
      end
    end else begin
      ready_o <= 1'b0;
      state   <= IDLE;
    end
  end
endmodule

// File: tb/tb_memory.sv
// tb_memory: randomized self-checking bench for memory against an array model.
module tb_memory;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [8:0]  addr_i = '0;
  logic [15:0] wdata_i = '0;
  logic        wr_rd_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [15:0] rdata_o;

  memory dut (
    .clk_i(clk_i), .rst_i(rst_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .wr_rd_i(wr_rd_i), .valid_i(valid_i), .ready_o(ready_o), .rdata_o(rdata_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_cmp = 0;
  int          n_err = 0;
  int          pulses = 0;
  logic [15:0] model [512];
  logic [15:0] last_rd = '0;
  bit          in_resp = 0;

  always @(negedge clk_i) if (ready_o) pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 512; i++) model[i] = '0;
    last_rd = '0;
    in_resp = 0;
  endtask

  // Issue one request; a request raised during the response cycle is accepted one edge later.
  task automatic req(input logic wr, input logic [8:0] a, input logic [15:0] d, input bit keep);
    int got;
    wr_rd_i = wr; addr_i = a; wdata_i = d; valid_i = 1'b1;
    got = 0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk_i); #1;
      if (ready_o) begin got = k; break; end
    end
    check("latency", got, in_resp ? 2 : 1);
    if (wr) begin
      check("rdata_hold_on_write", rdata_o, last_rd);
      model[a] = d;
    end else begin
      last_rd = model[a];
      check($sformatf("read@%0h", a), rdata_o, model[a]);
    end
    if (!keep) valid_i = 1'b0;
    in_resp = 1;
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk_i); #1;
      check("idle_ready", ready_o, 1'b0);
      check("idle_rdata", rdata_o, last_rd);
    end
    in_resp = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    logic [8:0] a;
    clear_model();
    #2 rst_i = 1'b0;
    #3;
    check("reset_ready", ready_o, 1'b0);
    check("reset_rdata", rdata_o, 16'h0);
    #7 rst_i = 1'b1;
    req(0, 9'd5, 16'h0, 0);
    idle(2);

    req(1, 9'h1F0, 16'hA5C3, 0);
    idle(1);
    req(0, 9'h1F0, 16'h0, 0);
    check("single_rd", rdata_o, 16'hA5C3);
    idle(2);

    req(1, 9'd3, 16'h1111, 1);
    req(0, 9'd3, 16'h0, 0);
    check("b2b_rd", rdata_o, 16'h1111);
    idle(1);

    req(1, 9'd0, 16'hFFFF, 0);
    req(1, 9'd511, 16'h0001, 0);
    req(0, 9'd0, 16'h0, 0);
    check("bound_lo", rdata_o, 16'hFFFF);
    req(0, 9'd511, 16'h0, 0);
    check("bound_hi", rdata_o, 16'h0001);
    idle(1);

    p0 = pulses;
    for (int i = 0; i < 512; i++) req(1, 9'(i), 16'($urandom), 1);
    for (int i = 0; i < 512; i++) req(0, 9'(i), 16'h0, i != 511);
    idle(2);
    check("sweep_pulses", pulses - p0, 1024);

    for (int i = 0; i < 300; i++) begin
      a = 9'($urandom_range(0, 511));
      req(1'($urandom), a, 16'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(1);

    req(1, 9'd7, 16'hBEEF, 0);
    #2 rst_i = 1'b0;
    #1;
    check("async_rst_ready", ready_o, 1'b0);
    check("async_rst_rdata", rdata_o, 16'h0);
    #10 rst_i = 1'b1;
    clear_model();
    req(0, 9'd7, 16'h0, 0);
    check("post_rst_rd7", rdata_o, 16'h0);
    req(0, 9'd3, 16'h0, 0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
